dmem_rmw_ctrl: RTL and testbench

// Data-memory access controller between the core's MEM stage and port 1 of DPBRAMVarWidth.

---
 rtl/dmem_rmw_ctrl_pkg.sv | 43 ++++
 rtl/dmem_rmw_ctrl_if.sv | 26 ++
 rtl/dmem_rmw_ctrl_lane_fmt.sv | 46 ++++
 rtl/dmem_rmw_ctrl.sv | 169 ++++++++++++++++
 tb/tb_dmem_rmw_ctrl.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_rmw_ctrl_pkg.sv
// Shared types for the data-memory RMW controller: funct3 codes, FSM states,
// lane widths and the request legality rule.
// Imported by the controller top and its lane formatter.
package dmem_rmw_ctrl_pkg;

    localparam int XLEN   = 32;
    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LD_WAIT,
        S_ST_MERGE,
        S_RSP
    } state_e;

    // 1 when the request must be rejected: unknown size code, unsigned store,
    // or an address not aligned to the access size.
    function automatic logic req_illegal(input logic       we,
                                         input logic [2:0] f3,
                                         input logic [1:0] lo);
        logic bad;
        bad = 1'b0;
        case (f3)
            F3_B:    bad = 1'b0;
            F3_BU:   bad = we;
            F3_H:    bad = lo[0];
            F3_HU:   bad = we | lo[0];
            F3_W:    bad = (lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_rmw_ctrl_if.sv
// Core-side request/response bundle of the data-memory controller.
// master = MEM stage (drives req_*), slave = controller (drives req_ready, rsp_*).
// req transfers on req_valid & req_ready; rsp_valid is a 1-cycle pulse, never stalled.
interface dmem_rmw_ctrl_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wd;
    logic        rsp_valid;
    logic [31:0] rsp_rd;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wd,
        input  req_ready, rsp_valid, rsp_rd, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wd,
        output req_ready, rsp_valid, rsp_rd, rsp_err
    );

endinterface

// File: rtl/dmem_rmw_ctrl_lane_fmt.sv
// Lane formatter: load extract/extend and sub-word store merge by funct3 + addr[1:0].
// Latency: purely combinational.
// Backpressure: none (no state).
// Ports: i_funct3/i_addr_lo select the lane, i_word is the BRAM word, i_st_dat the
// LSB-aligned store data; o_ld_dat is the extended load, o_st_word the merged word.
module dmem_rmw_ctrl_lane_fmt
    import dmem_rmw_ctrl_pkg::*;
(
    input  logic [2:0]      i_funct3,
    input  logic [1:0]      i_addr_lo,
    input  logic [XLEN-1:0] i_word,
    input  logic [XLEN-1:0] i_st_dat,
    output logic [XLEN-1:0] o_ld_dat,
    output logic [XLEN-1:0] o_st_word
);

    logic [BYTE_W-1:0] w_byte;
    logic [HALF_W-1:0] w_half;

    assign w_byte = i_word[{i_addr_lo, 3'b000} +: BYTE_W];
    assign w_half = i_word[{i_addr_lo[1], 4'b0000} +: HALF_W];

    always_comb begin
        o_ld_dat = '0;
        case (i_funct3)
            F3_B:    o_ld_dat = {{(XLEN-BYTE_W){w_byte[BYTE_W-1]}}, w_byte};
            F3_BU:   o_ld_dat = {{(XLEN-BYTE_W){1'b0}}, w_byte};
            F3_H:    o_ld_dat = {{(XLEN-HALF_W){w_half[HALF_W-1]}}, w_half};
            F3_HU:   o_ld_dat = {{(XLEN-HALF_W){1'b0}}, w_half};
            F3_W:    o_ld_dat = i_word;
            default: o_ld_dat = '0;
        endcase
    end

    // Only the addressed lane is replaced; the rest of the word is what the BRAM holds.
    always_comb begin
        o_st_word = i_word;
        case (i_funct3)
            F3_B:    o_st_word[{i_addr_lo, 3'b000} +: BYTE_W]     = i_st_dat[BYTE_W-1:0];
            F3_H:    o_st_word[{i_addr_lo[1], 4'b0000} +: HALF_W] = i_st_dat[HALF_W-1:0];
            F3_W:    o_st_word = i_st_dat;
            default: o_st_word = i_word;
        endcase
    end

endmodule

// File: rtl/dmem_rmw_ctrl.sv
// Data-memory controller: RV32I loads/stores onto a word-wide BRAM port, RMW for SB/SH.
// Latency: SW/error rsp at T+1, loads and SB/SH rsp at T+2 (T = accept cycle).
// Backpressure: req_ready only in IDLE, one request in flight; response cannot stall.
// Ports: i_clk, i_rst_n (async active-low), req_if (slave: request/response),
// o_mem_en/we/addr/wd and i_mem_rd to BRAM port 1 (read data one cycle after en).
module dmem_rmw_ctrl
    import dmem_rmw_ctrl_pkg::*;
#(
    parameter int SIZE_BITS = 2048
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    dmem_rmw_ctrl_if.slave               req_if,
    output logic                         o_mem_en,
    output logic                         o_mem_we,
    output logic [$clog2(SIZE_BITS/32-1)-1:0] o_mem_addr,
    output logic [XLEN-1:0]              o_mem_wd,
    input  logic [XLEN-1:0]              i_mem_rd
);

    localparam int ADDRWIDTH = $clog2(SIZE_BITS/32 - 1);

    state_e                 r_state;
    state_e                 w_next;

    logic                   r_we;
    logic [2:0]             r_f3;
    logic [ADDRWIDTH-1:0]   r_idx;
    logic [1:0]             r_lo;
    logic [XLEN-1:0]        r_wd;

    logic                   r_rsp_valid;
    logic [XLEN-1:0]        r_rsp_rd;
    logic                   r_rsp_err;

    logic                   w_accept;
    logic                   w_req_err;
    logic [ADDRWIDTH-1:0]   w_req_idx;
    logic [XLEN-1:0]        w_ld_dat;
    logic [XLEN-1:0]        w_st_word;
    logic                   w_mem_en;
    logic                   w_mem_we;
    logic [ADDRWIDTH-1:0]   w_mem_addr;
    logic [XLEN-1:0]        w_mem_wd;
    logic                   w_unused;

    // Address bits above the BRAM size are dropped, so accesses wrap.
    assign w_req_idx = req_if.req_addr[ADDRWIDTH+1:2];
    assign w_unused  = ^req_if.req_addr[XLEN-1:ADDRWIDTH+2];

    assign w_accept  = req_if.req_valid && (r_state == S_IDLE);
    assign w_req_err = req_illegal(req_if.req_we, req_if.req_funct3, req_if.req_addr[1:0]);

    // Both the load path (LD_WAIT) and the merge path (ST_MERGE) work from latched fields.
    dmem_rmw_ctrl_lane_fmt u_lane_fmt (
        .i_funct3  (r_f3),
        .i_addr_lo (r_lo),
        .i_word    (i_mem_rd),
        .i_st_dat  (r_wd),
        .o_ld_dat  (w_ld_dat),
        .o_st_word (w_st_word)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_mem_en   = 1'b0;
        w_mem_we   = 1'b0;
        w_mem_addr = r_idx;
        w_mem_wd   = '0;
        case (r_state)
            S_IDLE: begin
                if (req_if.req_valid) begin
                    if (w_req_err) begin
                        w_next = S_RSP;
                    end else begin
                        w_mem_en   = 1'b1;
                        w_mem_addr = w_req_idx;
                        w_mem_wd   = req_if.req_wd;
                        if (!req_if.req_we) begin
                            w_next = S_LD_WAIT;
                        end else if (req_if.req_funct3 == F3_W) begin
                            w_mem_we = 1'b1;
                            w_next   = S_RSP;
                        end else begin
                            // Sub-word store: read the word now, write the merge next cycle.
                            w_next = S_ST_MERGE;
                        end
                    end
                end
            end
            S_LD_WAIT: begin
                w_next = S_IDLE;
            end
            S_ST_MERGE: begin
                w_mem_en = 1'b1;
                w_mem_we = 1'b1;
                w_mem_wd = w_st_word;
                w_next   = S_RSP;
            end
            S_RSP: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Gate with reset so an in-flight merge write is dropped the instant reset asserts.
    assign o_mem_en   = w_mem_en & i_rst_n;
    assign o_mem_we   = w_mem_we & i_rst_n;
    assign o_mem_addr = w_mem_addr;
    assign o_mem_wd   = w_mem_wd;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_we        <= 1'b0;
            r_f3        <= '0;
            r_idx       <= '0;
            r_lo        <= '0;
            r_wd        <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rd    <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            if (w_accept) begin
                r_we  <= req_if.req_we;
                r_f3  <= req_if.req_funct3;
                r_idx <= w_req_idx;
                r_lo  <= req_if.req_addr[1:0];
                r_wd  <= req_if.req_wd;
                if (w_req_err) begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_err   <= 1'b1;
                    r_rsp_rd    <= '0;
                end else if (req_if.req_we && (req_if.req_funct3 == F3_W)) begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_err   <= 1'b0;
                    r_rsp_rd    <= '0;
                end
            end
            if (r_state == S_LD_WAIT) begin
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= 1'b0;
                r_rsp_rd    <= w_ld_dat;
            end
            if (r_state == S_ST_MERGE) begin
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= 1'b0;
                r_rsp_rd    <= '0;
            end
        end
    end

    assign req_if.req_ready = (r_state == S_IDLE);
    assign req_if.rsp_valid = r_rsp_valid;
    assign req_if.rsp_rd    = r_rsp_rd;
    assign req_if.rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_dmem_rmw_ctrl.sv
// Bench for dmem_rmw_ctrl paired with a 64-word BRAM model; directed cases,
// randomized traffic and a final read-back sweep against a word-array reference.
module tb_dmem_rmw_ctrl;

    localparam int SIZE_BITS = 2048;
    localparam int AW        = $clog2(SIZE_BITS/32 - 1);
    localparam int NWORDS    = SIZE_BITS / 32;

    logic          clk;
    logic          rst_n;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wd;
    logic [31:0]   mem_rd;

    dmem_rmw_ctrl_if ifc ();

    dmem_rmw_ctrl #(.SIZE_BITS(SIZE_BITS)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .req_if     (ifc),
        .o_mem_en   (mem_en),
        .o_mem_we   (mem_we),
        .o_mem_addr (mem_addr),
        .o_mem_wd   (mem_wd),
        .i_mem_rd   (mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM port model: synchronous read, output 0 when not enabled.
    logic [31:0] bram [NWORDS];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) bram[mem_addr] <= mem_wd;
            mem_rd <= bram[mem_addr];
        end else begin
            mem_rd <= 32'h0;
        end
    end

    int en_cnt = 0;
    always @(posedge clk) if (mem_en) en_cnt++;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] ref_mem [NWORDS];
    logic [31:0] last_rd;
    logic        last_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Transaction-level reference: result, error, response latency and BRAM accesses.
    task automatic ref_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, output logic [31:0] rd, output logic err,
                           output int lat, output int n_en);
        int          idx;
        int          sh;
        logic [31:0] w;
        logic [31:0] mask;
        logic [7:0]  b;
        logic [15:0] h;
        idx = int'(addr[7:2]);
        sh  = 8 * int'(addr[1:0]);
        w   = ref_mem[idx];
        b   = 8'((w >> sh) & 32'hFF);
        h   = 16'((w >> sh) & 32'hFFFF);
        rd  = 32'h0;
        case (f3)
            3'd0: err = 1'b0;
            3'd1: err = addr[0];
            3'd2: err = (addr[1:0] != 2'b00);
            3'd4: err = we;
            3'd5: err = we | addr[0];
            default: err = 1'b1;
        endcase
        if (err) begin
            lat = 1; n_en = 0;
        end else if (!we) begin
            lat = 2; n_en = 1;
            case (f3)
                3'd0: rd = {{24{b[7]}}, b};
                3'd4: rd = {24'h0, b};
                3'd1: rd = {{16{h[15]}}, h};
                3'd5: rd = {16'h0, h};
                default: rd = w;
            endcase
        end else if (f3 == 3'd2) begin
            lat = 1; n_en = 1;
            ref_mem[idx] = wd;
        end else begin
            lat = 2; n_en = 2;
            mask = (f3 == 3'd0) ? 32'hFF : 32'hFFFF;
            ref_mem[idx] = (w & ~(mask << sh)) | ((wd & mask) << sh);
        end
    endtask

    // Called at a negedge; returns at a negedge.
    task automatic run(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd);
        logic [31:0] e_rd;
        logic        e_err;
        int          e_lat, e_en, lat, en0;
        bit          got;
        ref_txn(we, f3, addr, wd, e_rd, e_err, e_lat, e_en);
        chk("ready_before_req", 32'(ifc.req_ready), 32'd1);
        ifc.req_valid  = 1'b1;
        ifc.req_we     = we;
        ifc.req_funct3 = f3;
        ifc.req_addr   = addr;
        ifc.req_wd     = wd;
        en0 = en_cnt;
        @(posedge clk);
        #1;
        ifc.req_valid  = 1'b0;
        ifc.req_we     = 1'($urandom);
        ifc.req_addr   = $urandom;
        ifc.req_wd     = $urandom;
        got = 1'b0;
        lat = 0;
        for (int c = 1; c <= 8 && !got; c++) begin
            @(negedge clk);
            lat = c;
            if (ifc.rsp_valid) got = 1'b1;
        end
        if (!got) begin
            chk("rsp_timeout", 32'd0, 32'd1);
        end else begin
            chk("rsp_latency", 32'(lat), 32'(e_lat));
            chk("rsp_rd", ifc.rsp_rd, e_rd);
            chk("rsp_err", 32'(ifc.rsp_err), 32'(e_err));
            chk("ready_at_rsp", 32'(ifc.req_ready), 32'(!we && !e_err));
            last_rd  = ifc.rsp_rd;
            last_err = ifc.rsp_err;
            @(negedge clk);
            chk("rsp_single_pulse", 32'(ifc.rsp_valid), 32'd0);
            chk("ready_after_rsp", 32'(ifc.req_ready), 32'd1);
            chk("mem_access_count", 32'(en_cnt - en0), 32'(e_en));
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        for (int i = 0; i < NWORDS; i++) begin
            bram[i]    = 32'h0;
            ref_mem[i] = 32'h0;
        end
        last_rd        = 32'h0;
        last_err       = 1'b0;
        rst_n          = 1'b0;
        ifc.req_valid  = 1'b1;
        ifc.req_we     = 1'b0;
        ifc.req_funct3 = 3'd2;
        ifc.req_addr   = 32'h10;
        ifc.req_wd     = 32'h0;
        repeat (3) @(negedge clk);
        chk("reset_rsp_valid", 32'(ifc.rsp_valid), 32'd0);
        chk("reset_rsp_rd", ifc.rsp_rd, 32'h0);
        chk("reset_rsp_err", 32'(ifc.rsp_err), 32'd0);
        chk("reset_mem_en", 32'(mem_en), 32'd0);
        ifc.req_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_ready", 32'(ifc.req_ready), 32'd1);

        // Word store/load round trip and sub-word merges.
        run(1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
        run(1'b0, 3'd2, 32'h10, 32'h0);
        chk("lw_10", last_rd, 32'hDEADBEEF);
        run(1'b1, 3'd0, 32'h11, 32'h0000007F);
        run(1'b0, 3'd2, 32'h10, 32'h0);
        chk("sb_merge_word", last_rd, 32'hDEAD7FEF);
        run(1'b0, 3'd0, 32'h13, 32'h0);
        chk("lb_13", last_rd, 32'hFFFFFFDE);
        run(1'b0, 3'd4, 32'h13, 32'h0);
        chk("lbu_13", last_rd, 32'h000000DE);
        run(1'b1, 3'd1, 32'h12, 32'h00008001);
        run(1'b0, 3'd1, 32'h12, 32'h0);
        chk("lh_12", last_rd, 32'hFFFF8001);
        run(1'b0, 3'd5, 32'h12, 32'h0);
        chk("lhu_12", last_rd, 32'h00008001);
        run(1'b0, 3'd2, 32'h10, 32'h0);
        chk("sh_merge_word", last_rd, 32'h80017FEF);

        // Illegal requests: no BRAM access, memory untouched.
        run(1'b0, 3'd2, 32'h102, 32'h0);
        chk("err_lw_misalign", 32'(last_err), 32'd1);
        run(1'b1, 3'd1, 32'h13, 32'h5555);
        chk("err_sh_misalign", 32'(last_err), 32'd1);
        run(1'b0, 3'd3, 32'h10, 32'h0);
        chk("err_f3_011", 32'(last_err), 32'd1);
        run(1'b1, 3'd4, 32'h10, 32'h11);
        chk("err_store_unsigned", 32'(last_err), 32'd1);
        run(1'b0, 3'd2, 32'h10, 32'h0);
        chk("mem_intact_after_err", last_rd, 32'h80017FEF);

        // Address wrap: 0x110 aliases word 4.
        run(1'b1, 3'd2, 32'h110, 32'h12345678);
        run(1'b0, 3'd2, 32'h10, 32'h0);
        chk("wrap_lw_10", last_rd, 32'h12345678);

        // Reset during the merge cycle of an SB must drop the write.
        ifc.req_valid  = 1'b1;
        ifc.req_we     = 1'b1;
        ifc.req_funct3 = 3'd0;
        ifc.req_addr   = 32'h11;
        ifc.req_wd     = 32'hAA;
        @(posedge clk);
        #1;
        ifc.req_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_merge_mem_en", 32'(mem_en), 32'd0);
        chk("rst_merge_rsp_valid", 32'(ifc.rsp_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_merge_ready", 32'(ifc.req_ready), 32'd1);
        @(negedge clk);
        chk("rst_merge_no_rsp", 32'(ifc.rsp_valid), 32'd0);
        run(1'b0, 3'd2, 32'h10, 32'h0);
        chk("rst_merge_word_kept", last_rd, 32'h12345678);

        // Randomized traffic, biased towards aligned addresses and legal codes.
        for (int n = 0; n < 300; n++) begin
            we   = 1'($urandom);
            f3   = ($urandom_range(0, 9) == 0) ? 3'($urandom) :
                   (we ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5)));
            addr = $urandom & 32'h1FF;
            if ($urandom_range(0, 3) != 0) begin
                if (f3[1:0] == 2'd2) addr[1:0] = 2'b00;
                if (f3[1:0] == 2'd1) addr[0]   = 1'b0;
            end
            if ($urandom_range(0, 3) == 0) addr[31:9] = 23'($urandom);
            run(we, f3, addr, $urandom);
        end

        // Read back every word through the controller.
        for (int i = 0; i < NWORDS; i++) begin
            run(1'b0, 3'd2, 32'(i * 4), 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
